// File: rtl/io_ports_if.sv
// rtl/io_ports_if.sv - datapath-side bus into the memory-mapped I/O block.
interface io_ports_if #(parameter int WIDTH = 16);
   logic [15:0]      addr;
   logic [WIDTH-1:0] wdata;
   logic             we_io;
   logic [WIDTH-1:0] datos;
   logic             irq;

   modport master (output addr, output wdata, output we_io, input datos, input irq);
   modport slave  (input addr, input wdata, input we_io, output datos, output irq);
endinterface

// File: rtl/io_ports.sv
// rtl/io_ports.sv - memory-mapped I/O: 4 synchronized inputs, 4 output registers, reloadable down-timer.
module io_ports #(
   parameter logic [15:0] BASE  = 16'h0000,
   parameter int          WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   io_ports_if.slave        bus,
   input  logic [WIDTH-1:0] in_p0_i,
   input  logic [WIDTH-1:0] in_p1_i,
   input  logic [WIDTH-1:0] in_p2_i,
   input  logic [WIDTH-1:0] in_p3_i,
   output logic [WIDTH-1:0] out_p0_o,
   output logic [WIDTH-1:0] out_p1_o,
   output logic [WIDTH-1:0] out_p2_o,
   output logic [WIDTH-1:0] out_p3_o
);

   logic [WIDTH-1:0] in_raw [4];
   logic [WIDTH-1:0] sync1_q [4];
   logic [WIDTH-1:0] sync2_q [4];
   logic [WIDTH-1:0] out_q [4];
   logic [WIDTH-1:0] out_d [4];
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             en_q, en_d;
   logic             flag_q, flag_d;

   logic       sel;
   logic [3:0] off;
   logic       wr;

   assign in_raw[0] = in_p0_i;
   assign in_raw[1] = in_p1_i;
   assign in_raw[2] = in_p2_i;
   assign in_raw[3] = in_p3_i;

   assign sel = (bus.addr[15:4] == BASE[15:4]);
   assign off = bus.addr[3:0];
   assign wr  = bus.we_io & sel;

   always_comb begin
      out_d    = out_q;
      reload_d = reload_q;
      en_d     = en_q;
      flag_d   = flag_q;
      count_d  = count_q;

      if (wr && off[3:2] == 2'b01) begin
         out_d[off[1:0]] = bus.wdata;
      end
      if (wr && off == 4'hA) begin
         en_d = bus.wdata[0];
         if (bus.wdata[1]) begin
            flag_d = 1'b0;
         end
      end

      // A RELOAD write preempts this edge's timer step; expiry below overrides a FLAG clear.
      if (wr && off == 4'h8) begin
         reload_d = bus.wdata;
         count_d  = bus.wdata;
      end else if (en_q) begin
         if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            count_d = reload_q;
            flag_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            sync1_q[i] <= '0;
            sync2_q[i] <= '0;
            out_q[i]   <= '0;
         end
         reload_q <= '0;
         count_q  <= '0;
         en_q     <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            sync1_q[i] <= in_raw[i];
            sync2_q[i] <= sync1_q[i];
            out_q[i]   <= out_d[i];
         end
         reload_q <= reload_d;
         count_q  <= count_d;
         en_q     <= en_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      bus.datos = '0;
      if (sel) begin
         case (off)
            4'h0, 4'h1, 4'h2, 4'h3: bus.datos = sync2_q[off[1:0]];
            4'h4, 4'h5, 4'h6, 4'h7: bus.datos = out_q[off[1:0]];
            4'h8:    bus.datos = reload_q;
            4'h9:    bus.datos = count_q;
            4'hA:    bus.datos = {{(WIDTH-2){1'b0}}, flag_q, en_q};
            default: bus.datos = '0;
         endcase
      end
   end

   assign bus.irq  = flag_q;
   assign out_p0_o = out_q[0];
   assign out_p1_o = out_q[1];
   assign out_p2_o = out_q[2];
   assign out_p3_o = out_q[3];

endmodule

// File: tb/tb_io_ports.sv
// tb/tb_io_ports.sv - directed bench for io_ports.
module tb_io_ports;

   logic        clk;
   logic        reset;
   logic [15:0] in_p0, in_p1, in_p2, in_p3;
   logic [15:0] out_p0, out_p1, out_p2, out_p3;
   int          checks;
   int          failures;

   io_ports_if #(.WIDTH(16)) bus ();

   io_ports #(.BASE(16'h0000), .WIDTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .in_p0_i  (in_p0),
      .in_p1_i  (in_p1),
      .in_p2_i  (in_p2),
      .in_p3_i  (in_p3),
      .out_p0_o (out_p0),
      .out_p1_o (out_p1),
      .out_p2_o (out_p2),
      .out_p3_o (out_p3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.we_io = 1'b1;
      tick();
      bus.we_io = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
      bus.addr = a;
      #1;
      check(tag, {16'h0, bus.datos}, {16'h0, exp});
   endtask

   logic [15:0] seq [4];

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      bus.addr  = 16'h0;
      bus.wdata = 16'h0;
      bus.we_io = 1'b0;
      in_p0 = 16'h0; in_p1 = 16'h0; in_p2 = 16'h0; in_p3 = 16'h0;
      tick();
      tick();
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         rd($sformatf("reset_rd_%0h", i), 16'(i), 16'h0);
      end
      check("reset_irq", {31'h0, bus.irq}, 32'h0);

      wr(16'h0005, 16'h1234);
      check("out_p1_wr", {16'h0, out_p1}, 32'h1234);
      rd("rd_out_p1", 16'h0005, 16'h1234);
      wr(16'h0015, 16'hFFFF);
      check("unsel_wr", {16'h0, out_p1}, 32'h1234);
      wr(16'h0000, 16'hFFFF);
      rd("rd_in_p0_ro", 16'h0000, 16'h0000);

      #3;
      in_p3 = 16'hA5A5;
      bus.addr = 16'h0003;
      tick();
      rd("sync_edge1", 16'h0003, 16'h0000);
      tick();
      rd("sync_edge2", 16'h0003, 16'hA5A5);

      wr(16'h0008, 16'h0003);
      wr(16'h000A, 16'h0001);
      rd("cnt_start", 16'h0009, 16'h0003);
      check("irq_before", {31'h0, bus.irq}, 32'h0);
      seq[0] = 16'h2; seq[1] = 16'h1; seq[2] = 16'h0; seq[3] = 16'h3;
      for (int i = 0; i < 4; i++) begin
         tick();
         rd($sformatf("cnt_seq_%0d", i), 16'h0009, seq[i]);
         check($sformatf("irq_seq_%0d", i), {31'h0, bus.irq}, (i == 3) ? 32'h1 : 32'h0);
      end
      tick();
      rd("cnt_after", 16'h0009, 16'h0002);
      check("irq_sticky", {31'h0, bus.irq}, 32'h1);

      wr(16'h000A, 16'h0003);
      rd("ctrl_clear", 16'h000A, 16'h0001);
      rd("cnt_clear", 16'h0009, 16'h0001);
      tick();
      rd("cnt_zero", 16'h0009, 16'h0000);
      wr(16'h000A, 16'h0003);
      rd("ctrl_set_wins", 16'h000A, 16'h0003);
      rd("cnt_set_wins", 16'h0009, 16'h0003);
      check("irq_set_wins", {31'h0, bus.irq}, 32'h1);

      wr(16'h000A, 16'h0003);
      tick();
      tick();
      rd("cnt_pre_reload", 16'h0009, 16'h0000);
      wr(16'h0008, 16'h0007);
      rd("cnt_reload_wr", 16'h0009, 16'h0007);
      rd("reload_rd", 16'h0008, 16'h0007);
      check("flag_reload_wr", {31'h0, bus.irq}, 32'h0);

      wr(16'h000A, 16'h0000);
      rd("cnt_old_en", 16'h0009, 16'h0006);
      wr(16'h0008, 16'h0000);
      wr(16'h000A, 16'h0001);
      check("irq_r0_pre", {31'h0, bus.irq}, 32'h0);
      tick();
      check("irq_r0", {31'h0, bus.irq}, 32'h1);
      rd("cnt_r0", 16'h0009, 16'h0000);

      wr(16'h0006, 16'hBEEF);
      rd("rd_out_p2", 16'h0006, 16'hBEEF);
      #2;
      reset = 1'b1;
      #1;
      check("rst_out_p2", {16'h0, out_p2}, 32'h0);
      rd("rst_ctrl", 16'h000A, 16'h0000);
      check("rst_irq", {31'h0, bus.irq}, 32'h0);
      tick();
      reset = 1'b0;
      wr(16'h0008, 16'h0002);
      tick();
      tick();
      tick();
      rd("no_resume_cnt", 16'h0009, 16'h0002);
      check("no_resume_irq", {31'h0, bus.irq}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_ports.md
Name: io_ports

Overview:
- Memory-mapped I/O unit on the datapath's data side.
- Consumes the 16-bit address the datapath drives on its `direcciones` output, plus a write strobe and write data from the control unit.
- Returns read data combinationally on `datos`, which feeds the datapath's data mux in the same cycle.
- Contains 4 synchronized input ports, 4 output registers and a 16-bit reloadable down-timer with a sticky flag/irq.

Parameters:
- BASE, 16'h0000, base address of the block. Selected when addr[15:4] == BASE[15:4].
- WIDTH, 16, data width of ports, registers and timer.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- addr  input  16  address from the datapath `direcciones`
- wdata  input  WIDTH  write data
- we_io  input  1  write strobe, sampled at rising clk
- in_p0..in_p3  input  WIDTH each  external input ports, asynchronous to clk
- out_p0..out_p3  output  WIDTH each  output port registers
- datos  output  WIDTH  read data, combinational from addr
- irq  output  1  timer flag, equal to status bit 1

Behaviour:
- Address map, offset = addr[3:0], valid only when the block is selected:
  - 0x0–0x3: input port 0–3, read-only.
  - 0x4–0x7: out_p0–3, read/write.
  - 0x8: RELOAD, read/write.
  - 0x9: COUNT, read-only.
  - 0xA: CTRL. bit0 = EN (read/write); bit1 = FLAG (read; writing 1 clears it, writing 0 has no effect); other bits read 0.
  - 0xB–0xF, or block not selected: reads 0, writes ignored.
- Reset (asynchronous, immediate):
  - out_p0..3, RELOAD, COUNT, EN, FLAG and all synchronizer flops go to 0.
  - irq = 0. datos = 0 unless addr selects a nonzero register; after reset, every readable register is 0.
- Input synchronization:
  - Each input port passes through a 2-flop synchronizer.
  - A read returns the second-stage value.
  - Latency: an input change is visible on datos at the 2nd rising edge after it is applied.
- Reads: purely combinational from addr and current register state. No read side effects; reading FLAG does not clear it.
- Writes: take effect on the rising clk when we_io=1 and addr decodes to a writable register. The new value is visible on datos in the following cycle.
- Timer, evaluated on each rising clk:
  - EN=0: COUNT holds.
  - EN=1 and COUNT != 0: COUNT <= COUNT-1.
  - EN=1 and COUNT == 0: COUNT <= RELOAD and FLAG <= 1.
  - With RELOAD = N, the period is N+1 cycles. RELOAD = 0 sets FLAG every cycle.
- A write to RELOAD also loads COUNT <= wdata on the same edge. This overrides the decrement/expiry that edge; no flag is set that edge.
- FLAG clear (write CTRL with wdata[1]=1) on the same edge as a timer expiry: set wins, FLAG = 1.
- A CTRL write updates EN on the same edge. The timer step on that edge uses the old EN.
- Arithmetic is unsigned, modulo 2^WIDTH. COUNT never wraps below 0; it reloads instead.
- irq = FLAG (registered, glitch-free).
- Reset asserted mid-count clears the timer state immediately. Counting resumes only after EN is written 1.

Test Plan:
- Reset, then read offsets 0x0–0xF: all return 0, irq = 0. Assert reset mid-operation with out_p2 = 16'hBEEF and EN = 1: out_p2 = 0, EN = 0 without waiting for a clk edge.
- Write 16'h1234 to offset 0x5 with BASE=0: out_p1 = 16'h1234 after the edge, and a read of 0x5 returns it. Write addr 16'h0015 (block not selected): no change. Write 0x0 (input port): ignored.
- Drive in_p3 = 16'hA5A5 mid-cycle: a read of 0x3 returns the old value after the 1st edge and 16'hA5A5 after the 2nd edge.
- RELOAD = 3, then CTRL = 1:
  - COUNT reads 3, 2, 1, 0, 3, ... on successive cycles.
  - FLAG and irq rise on the edge where COUNT goes 0→3 and stay high.
  - Writing CTRL = 16'h0003 in a non-expiry cycle clears FLAG and keeps EN.
- Clear FLAG on the exact expiry edge: FLAG stays 1. Write RELOAD = 7 while COUNT = 0 and EN = 1: COUNT = 7, FLAG unchanged.
- RELOAD = 0, EN = 1: FLAG sets on the first edge, and COUNT stays 0.
